param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_pkg.sv | 22 ++
 rtl/param_fifo_ram.sv | 34 +++
 rtl/param_fifo.sv | 145 ++++++++++++++
 tb/tb_param_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg
// Shared constants and helpers for the parameterised FIFO slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_AEMPTY_THR : parameter defaults
//   count_op_e       : occupancy update selected each cycle
//   calc_ptr_width() : pointer width for a power-of-two depth
package param_fifo_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_AEMPTY_THR = 2;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } count_op_e;

    function automatic int calc_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// param_fifo_ram
// DEPTH x WIDTH storage array for param_fifo. No reset: contents are
// only meaningful between the FIFO's read and write pointers.
// Ports:
//   clk   : write clock
//   we    : write enable, commits wdata to mem[waddr] on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data, mem[raddr]
module param_fifo_ram #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// param_fifo
// Synchronous single-clock FIFO with occupancy count, threshold flags and
// sticky overflow/underflow error flags.
// Optional macro PARAM_FIFO_FWFT_EN selects first-word-fall-through reads;
// without it, read data is registered one cycle after an accepted read.
// Ports:
//   clk          : clock, all state changes on rising edge
//   res          : asynchronous active-low reset
//   clr          : synchronous flush, overrides wr_en/rd_en
//   wr_en, wdata : write request and data
//   rd_en        : read request
//   rdata, rvalid: read data and its valid indication
//   full, empty, almost_full, almost_empty : status decoded from count
//   count        : current occupancy, 0..DEPTH
//   overflow, underflow : sticky error flags, cleared by reset or clr
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = DEFAULT_AEMPTY_THR,
    localparam int PTR_WIDTH = calc_ptr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rvalid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT  = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AFULL_CNT  = (PTR_WIDTH+1)'(AFULL_THR);
    localparam logic [PTR_WIDTH:0] AEMPTY_CNT = (PTR_WIDTH+1)'(AEMPTY_THR);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [WIDTH-1:0]     head;
    logic                 rd_acc;
    logic                 wr_acc;
    count_op_e            count_op;

    // Flags are a pure decode of the registered count.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    // A write into a full FIFO is still accepted when a read frees the
    // head slot in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        count_op = CNT_HOLD;
        if (wr_acc && !rd_acc) begin
            count_op = CNT_INC;
        end else if (rd_acc && !wr_acc) begin
            count_op = CNT_DEC;
        end
    end

    param_fifo_ram #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !clr),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case (count_op)
                CNT_INC: count <= count + (PTR_WIDTH+1)'(1);
                CNT_DEC: count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head entry is always presented; gating with empty keeps rdata at zero
    // after reset or flush, since storage itself is never cleared.
    assign rdata  = empty ? '0 : head;
    assign rvalid = ~empty;
`else
    // Registered read: data appears one cycle after the accepted read and
    // holds until the next one.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (clr) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= head;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo
// Directed bench for param_fifo with default parameters. A queue holds
// the words the FIFO should contain; reads pop it and the observed read
// data is compared against the popped word. Status flags are derived from
// the queue occupancy.
module tb_param_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             res;
    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] sb_q[$];
    logic             m_ovf;
    logic             m_udf;
    logic             m_rvalid;
    logic [WIDTH-1:0] m_rdata;

    param_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .res          (res),
        .clr          (clr),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int n;
        n = sb_q.size();
        checkValue("count",        32'(count),        32'(n));
        checkValue("full",         32'(full),         32'(n == DEPTH));
        checkValue("empty",        32'(empty),        32'(n == 0));
        checkValue("almost_full",  32'(almost_full),  32'(n >= 14));
        checkValue("almost_empty", 32'(almost_empty), 32'(n <= 2));
        checkValue("overflow",     32'(overflow),     32'(m_ovf));
        checkValue("underflow",    32'(underflow),    32'(m_udf));
`ifdef PARAM_FIFO_FWFT_EN
        checkValue("rvalid",       32'(rvalid),       32'(n != 0));
        checkValue("rdata",        32'(rdata),        (n != 0) ? 32'(sb_q[0]) : 32'h0);
`else
        checkValue("rvalid",       32'(rvalid),       32'(m_rvalid));
        checkValue("rdata",        32'(rdata),        32'(m_rdata));
`endif
    endtask

    // Drives one cycle of inputs, predicts acceptance from the queue
    // occupancy, then updates the model after the edge and compares.
    task automatic applyStimulus(input bit wr, input logic [WIDTH-1:0] wd, input bit rd, input bit cl);
        bit rd_acc;
        bit wr_acc;
        wr_en  = wr;
        wdata  = wd;
        rd_en  = rd;
        clr    = cl;
        rd_acc = rd && (sb_q.size() != 0);
        wr_acc = wr && ((sb_q.size() != DEPTH) || rd_acc);
        @(posedge clk);
        #1;
        if (cl) begin
            sb_q.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
        end else begin
            m_rvalid = rd_acc;
            if (rd_acc) begin
                m_rdata = sb_q.pop_front();
            end
            if (wr_acc) begin
                sb_q.push_back(wd);
            end
            if (wr && !wr_acc) begin
                m_ovf = 1'b1;
            end
            if (rd && !rd_acc) begin
                m_udf = 1'b1;
            end
        end
        checkOutput();
    endtask

    initial begin
        res      = 1'b0;
        clr      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wdata    = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;

        // Reset state while res is held low.
        #12;
        $display("[TB] reset state");
        checkOutput();
        res = 1'b1;

        // Fill with 0x00..0x0F, sweeping the almost_full/almost_empty thresholds.
        $display("[TB] fill to full");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        end
        checkValue("full_after_16", 32'(full), 32'h1);

        // Write while full is rejected.
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkValue("overflow_17th", 32'(overflow), 32'h1);

        // Drain in order, then one read too many.
        $display("[TB] drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkValue("underflow_extra", 32'(underflow), 32'h1);

        // Flush clears sticky flags.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Write and read together while empty: write only.
        $display("[TB] simultaneous access at empty and full");
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Write and read together while full: both accepted.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
        checkValue("no_overflow_full_rw", 32'(overflow), 32'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Streaming at count=5 across several pointer wraps.
        $display("[TB] streaming");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'(8'h45 + i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-burst at count=9.
        $display("[TB] async reset mid-burst");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        end
        wdata = 8'hAA;
        #3;
        res = 1'b0;
        #1;
        sb_q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        checkOutput();
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput();
        #2;
        res = 1'b1;

        // Sticky flag then flush with a concurrent write.
        $display("[TB] flush overrides write");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'hDD, 1'b0, 1'b1);
        checkValue("clr_count", 32'(count), 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end

`ifdef PARAM_FIFO_FWFT_EN
        // Head word is visible the cycle after the write, with no read.
        $display("[TB] fwft presentation");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkValue("fwft_rvalid", 32'(rvalid), 32'h1);
        checkValue("fwft_rdata",  32'(rdata),  32'hA5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
